// File: rtl/simplez_rxfifo.sv
`default_nettype none
// ============================================================================
// Module   : simplez_rxfifo
// Purpose  : Keyboard-port bus responder for the Simplez processor. Buffers
//            bytes delivered by uart_rx in a small FIFO and returns them, or a
//            status word, on processor reads.
// Ports    : clk     - system clock, all state changes on the rising edge
//            rst     - synchronous active-high reset
//            addr    - processor bus address (instruction CD field)
//            rd      - one-cycle read strobe, qualified by addr
//            rcv     - one-cycle "byte received" pulse from uart_rx
//            rxdata  - received byte, valid while rcv=1
//            dout    - read data back to the processor (held until next read)
//            ack     - one-cycle pulse: dout carries a fresh response
//            irq     - level, FIFO not empty
// Status   : {4'b0, cnt[3:0], 1'b0, ovf, full, not_empty}
// Config   : define SIMPLEZ_RXFIFO_COUNT_EN to report occupancy in status
//            bits [7:4]; otherwise those bits read 0.
// Params   : STATUS_ADR, DATA_ADR, DEPTH (2, 4 or 8)
// Revision : 1.0 - initial release
// ============================================================================
module simplez_rxfifo #(
    parameter logic [8:0] STATUS_ADR = 9'd510,
    parameter logic [8:0] DATA_ADR   = 9'd511,
    parameter int         DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  addr,
    input  logic        rd,
    input  logic        rcv,
    input  logic [7:0]  rxdata,
    output logic [11:0] dout,
    output logic        ack,
    output logic        irq
);

    // DEPTH is a power of two, so pointers wrap modulo DEPTH naturally.
    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic [11:0]        r_dout;
    logic               r_ack;

    logic               w_data_rd;
    logic               w_stat_rd;
    logic               w_full;
    logic               w_not_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf_evt;
    logic [3:0]         w_cnt_field;
    logic [11:0]        w_status;

    assign w_data_rd   = rd && (addr == DATA_ADR);
    assign w_stat_rd   = rd && (addr == STATUS_ADR);
    assign w_full      = (r_count == c_CNT_MAX);
    assign w_not_empty = (r_count != '0);

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // accepted when a data read drains the head concurrently. An empty FIFO
    // never bypasses: the read returns 0 and the byte is just stored.
    assign w_pop       = w_data_rd && w_not_empty;
    assign w_push      = rcv && (!w_full || w_pop);
    assign w_ovf_evt   = rcv && w_full && !w_pop;

`ifdef SIMPLEZ_RXFIFO_COUNT_EN
    assign w_cnt_field = 4'(r_count);
`else
    assign w_cnt_field = 4'b0000;
`endif

    // Status reflects registered state, i.e. the view before this edge.
    assign w_status = {4'b0000, w_cnt_field, 1'b0, r_ovf, w_full, w_not_empty};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_dout  <= 12'h000;
            r_ack   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            // A new overflow wins over the clear-on-status-read so that an
            // overflow landing on the read edge is not lost.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end

            r_ack <= w_data_rd || w_stat_rd;

            if (w_stat_rd) begin
                r_dout <= w_status;
            end else if (w_data_rd) begin
                r_dout <= w_pop ? {4'b0000, r_mem[r_rptr]} : 12'h000;
            end
        end
    end

    // Storage is deliberately left without reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= rxdata;
        end
    end

    assign dout = r_dout;
    assign ack  = r_ack;
    assign irq  = w_not_empty;

endmodule
`default_nettype wire

// File: tb/tb_simplez_rxfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_simplez_rxfifo
// Purpose  : Self-checking bench for simplez_rxfifo. Directed scenarios plus a
//            randomized run, compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simplez_rxfifo;

    localparam logic [8:0] STATUS_ADR = 9'd510;
    localparam logic [8:0] DATA_ADR   = 9'd511;
    localparam int         DEPTH      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  addr;
    logic        rd;
    logic        rcv;
    logic [7:0]  rxdata;
    logic [11:0] dout;
    logic        ack;
    logic        irq;

    always #5 clk = ~clk;

    simplez_rxfifo #(
        .STATUS_ADR (STATUS_ADR),
        .DATA_ADR   (DATA_ADR),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .rd     (rd),
        .rcv    (rcv),
        .rxdata (rxdata),
        .dout   (dout),
        .ack    (ack),
        .irq    (irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte queue, sticky overflow, last response.
    logic [7:0]  m_q[$];
    logic        m_ovf  = 1'b0;
    logic [11:0] m_dout = 12'h000;
    logic        m_ack  = 1'b0;

    function automatic logic [11:0] status_word(input int n, input logic o);
        logic [3:0] cf;
        cf = 4'b0000;
`ifdef SIMPLEZ_RXFIFO_COUNT_EN
        cf = 4'(n);
`endif
        return {4'b0000, cf, 1'b0, o, (n == DEPTH), (n != 0)};
    endfunction

    task automatic model_edge(input logic r, input logic [8:0] a, input logic v,
                              input logic [7:0] d, input logic rs);
        int  n;
        bit  drd;
        bit  srd;
        bit  popped;
        if (rs) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_dout = 12'h000;
            m_ack  = 1'b0;
        end else begin
            n      = m_q.size();
            drd    = r && (a == DATA_ADR);
            srd    = r && (a == STATUS_ADR);
            popped = 1'b0;
            m_ack  = drd || srd;
            if (srd) begin
                m_dout = status_word(n, m_ovf);
            end else if (drd) begin
                if (n > 0) begin
                    m_dout = {4'b0000, m_q.pop_front()};
                    popped = 1'b1;
                end else begin
                    m_dout = 12'h000;
                end
            end
            if (v && (n < DEPTH || popped)) begin
                m_q.push_back(d);
            end
            if (v && n == DEPTH && !popped) begin
                m_ovf = 1'b1;
            end else if (srd) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    task automatic chk12(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: drive, let the edge happen, update model, sample #1 later.
    task automatic step(input string tag, input logic r, input logic [8:0] a,
                        input logic v, input logic [7:0] d, input logic rs);
        rst    = rs;
        rd     = r;
        addr   = a;
        rcv    = v;
        rxdata = d;
        @(posedge clk);
        model_edge(r, a, v, d, rs);
        #1;
        rst = 1'b0;
        rd  = 1'b0;
        rcv = 1'b0;
        chk12({tag, "_dout"}, dout, m_dout);
        chk1({tag, "_ack"}, ack, m_ack);
        chk1({tag, "_irq"}, irq, (m_q.size() != 0));
    endtask

    logic [7:0]  v8;
    logic [8:0]  ra;
    logic        rr;
    logic        rv;
    logic        rs;
    logic [11:0] full_stat;
    logic [11:0] ovf_stat;

    initial begin
        rst = 1'b0; rd = 1'b0; rcv = 1'b0; addr = 9'd0; rxdata = 8'h00;
`ifdef SIMPLEZ_RXFIFO_COUNT_EN
        full_stat = 12'h083;
        ovf_stat  = 12'h087;
`else
        full_stat = 12'h003;
        ovf_stat  = 12'h007;
`endif
        @(negedge clk);

        // Reset and first status read
        step("rst0", 0, 9'd0, 0, 8'h00, 1);
        step("rst1", 0, 9'd0, 0, 8'h00, 1);
        chk12("rst_dout_const", dout, 12'h000);
        chk1("rst_irq_const", irq, 1'b0);
        step("stat0", 1, STATUS_ADR, 0, 8'h00, 0);
        chk1("stat0_ack_const", ack, 1'b1);
        chk12("stat0_dout_const", dout, 12'h000);
        step("stat0_idle", 0, 9'd0, 0, 8'h00, 0);
        chk1("ack_single_cycle", ack, 1'b0);

        // Two bytes in, two out, then empty read
        step("push41", 0, 9'd0, 1, 8'h41, 0);
        step("push42", 0, 9'd0, 1, 8'h42, 0);
        step("rd41", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("rd41_const", dout, 12'h041);
        chk1("rd41_irq_const", irq, 1'b1);
        step("rd42", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("rd42_const", dout, 12'h042);
        chk1("rd42_irq_const", irq, 1'b0);
        step("rd_empty", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("rd_empty_const", dout, 12'h000);

        // Non-matching address: no ack, dout held
        step("other_adr", 1, 9'd100, 1, 8'h33, 0);
        chk1("other_adr_ack_const", ack, 1'b0);
        step("rd33", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("rd33_const", dout, 12'h033);

        // Overflow: nine pushes into DEPTH=8
        for (int i = 0; i < 9; i++) begin
            step("fill9", 0, 9'd0, 1, 8'(i), 0);
        end
        step("stat_ovf", 1, STATUS_ADR, 0, 8'h00, 0);
        chk12("stat_ovf_const", dout, ovf_stat);
        step("stat_clr", 1, STATUS_ADR, 0, 8'h00, 0);
        chk12("stat_clr_const", dout, full_stat);
        for (int i = 0; i < 8; i++) begin
            step("drain8", 1, DATA_ADR, 0, 8'h00, 0);
            chk12("drain8_const", dout, {4'b0000, 8'(i)});
        end
        step("drain_empty", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("byte08_lost", dout, 12'h000);

        // Overflow concurrent with status read keeps ovf set
        for (int i = 0; i < 8; i++) begin
            step("fill8a", 0, 9'd0, 1, 8'h10 + 8'(i), 0);
        end
        step("ovf_and_stat", 1, STATUS_ADR, 1, 8'hEE, 0);
        step("ovf_kept", 1, STATUS_ADR, 0, 8'h00, 0);
        chk12("ovf_kept_const", dout, ovf_stat);
        for (int i = 0; i < 8; i++) begin
            step("drain8a", 1, DATA_ADR, 0, 8'h00, 0);
        end

        // Full FIFO, push concurrent with pop: no overflow, AA read last
        for (int i = 0; i < 8; i++) begin
            step("fill8b", 0, 9'd0, 1, 8'h01 + 8'(i), 0);
        end
        step("push_pop_full", 1, DATA_ADR, 1, 8'hAA, 0);
        chk12("push_pop_full_const", dout, 12'h001);
        step("stat_no_ovf", 1, STATUS_ADR, 0, 8'h00, 0);
        chk12("stat_no_ovf_const", dout, full_stat);
        for (int i = 0; i < 8; i++) begin
            step("drain8b", 1, DATA_ADR, 0, 8'h00, 0);
        end
        chk12("aa_last_const", dout, 12'h0AA);

        // Empty FIFO, push concurrent with read: no bypass
        step("nobypass", 1, DATA_ADR, 1, 8'h55, 0);
        chk12("nobypass_const", dout, 12'h000);
        step("rd55", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("rd55_const", dout, 12'h055);

        // Reset dominates a concurrent data read
        for (int i = 0; i < 3; i++) begin
            step("q3", 0, 9'd0, 1, 8'hC0 + 8'(i), 0);
        end
        step("rst_rd", 1, DATA_ADR, 1, 8'h99, 1);
        chk1("rst_rd_ack_const", ack, 1'b0);
        chk1("rst_rd_irq_const", irq, 1'b0);
        step("rd_after_rst", 1, DATA_ADR, 0, 8'h00, 0);
        chk12("rd_after_rst_const", dout, 12'h000);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 59) == 0);
            rr = $urandom_range(0, 1);
            rv = ($urandom_range(0, 2) != 0);
            v8 = 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    ra = DATA_ADR;
                2:       ra = STATUS_ADR;
                default: ra = 9'($urandom_range(0, 509));
            endcase
            step("rand", rr, ra, rv, v8, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
